// File: rtl/alu_functional_unit_pkg.sv
// Shared types and opcode constants for the integer ALU functional unit.
// Opcode 8 is only decoded as a multiply when ALU_MUL_EN is defined.
package alu_functional_unit_pkg;

  localparam int ROB_IDX_W_DEF = 4;
  localparam int DATA_W_DEF    = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef struct packed {
    logic [ROB_IDX_W_DEF-1:0] rob_idx;
    logic [DATA_W_DEF-1:0]    instr;
    logic [DATA_W_DEF-1:0]    val1;
    logic [DATA_W_DEF-1:0]    val2;
  } issue_t;

  typedef struct packed {
    logic [ROB_IDX_W_DEF-1:0] rob_idx;
    logic [DATA_W_DEF-1:0]    value;
  } cdb_entry_t;

endpackage

// File: rtl/alu_functional_unit_result_fifo.sv
// Parameterised-depth valid/ready FIFO of CDB entries with an occupancy count.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module alu_functional_unit_result_fifo
  import alu_functional_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  input  cdb_entry_t       push_data,
  output logic             push_ready,
  output logic             pop_valid,
  output cdb_entry_t       pop_data,
  input  logic             pop_ready,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cdb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_valid  = (count != '0);
  assign do_pop     = pop_valid && pop_ready;
  assign push_ready = (count != CNT_W'(DEPTH)) || do_pop;
  assign do_push    = push_valid && push_ready;
  // Empty head reads as zero so the bus shows nothing stale after reset or flush.
  assign pop_data   = pop_valid ? mem[head] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= wrap_inc(tail);
      if (do_pop)  head <= wrap_inc(head);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[tail] <= push_data;
  end

endmodule

// File: rtl/alu_functional_unit.sv
// Two-stage integer ALU functional unit feeding a small CDB result queue.
// Define ALU_MUL_EN to decode opcode 8 as a 16-bit truncating multiply.
module alu_functional_unit
  import alu_functional_unit_pkg::*;
#(
  parameter int RESULT_DEPTH = 2,
  parameter int ROB_IDX_W    = ROB_IDX_W_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [ROB_IDX_W-1:0] in_instr_index,
  input  logic [DATA_W-1:0]    in_instr_full,
  input  logic [DATA_W-1:0]    in_val1,
  input  logic [DATA_W-1:0]    in_val2,
  output logic                 busy,
  output logic                 res_valid,
  output logic [ROB_IDX_W-1:0] res_rob_index,
  output logic [DATA_W-1:0]    res_value,
  input  logic                 res_ready,
  output logic                 overflow_err
);

  localparam int CNT_W = $clog2(RESULT_DEPTH + 1);

  issue_t           in_bundle;
  issue_t           s1_q;
  logic             s1_valid;
  logic             s1_advance;
  logic             accept;
  logic [3:0]       op;
  logic [DATA_W-1:0] alu_out;
  cdb_entry_t       result;
  cdb_entry_t       head;
  logic             q_push_ready;
  logic [CNT_W-1:0] q_count;
  logic             unused_instr_bits;

  assign in_bundle = '{rob_idx: in_instr_index, instr: in_instr_full,
                       val1: in_val1, val2: in_val2};
  assign op        = s1_q.instr[15:12];
  // Register operands arrive already resolved, so the low instruction fields carry nothing here.
  assign unused_instr_bits = ^s1_q.instr[11:0];

  assign s1_advance = s1_valid && q_push_ready;
  assign accept     = in_valid && (!s1_valid || s1_advance);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_q         <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_q     <= in_bundle;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
      if (in_valid && !accept) overflow_err <= 1'b1;
    end
  end

  always_comb begin
    alu_out = '0;
    case (op)
      OP_ADD:  alu_out = s1_q.val1 + s1_q.val2;
      OP_SUB:  alu_out = s1_q.val1 - s1_q.val2;
      OP_AND:  alu_out = s1_q.val1 & s1_q.val2;
      OP_OR:   alu_out = s1_q.val1 | s1_q.val2;
      OP_XOR:  alu_out = s1_q.val1 ^ s1_q.val2;
      OP_SHL:  alu_out = s1_q.val1 << s1_q.val2[3:0];
      OP_SHR:  alu_out = s1_q.val1 >> s1_q.val2[3:0];
      OP_SLT:  alu_out = ($signed(s1_q.val1) < $signed(s1_q.val2)) ? DATA_W'(1) : '0;
`ifdef ALU_MUL_EN
      OP_MUL:  alu_out = s1_q.val1 * s1_q.val2;
`endif
      default: alu_out = '0;
    endcase
  end

  assign result = '{rob_idx: s1_q.rob_idx, value: alu_out};

  alu_functional_unit_result_fifo #(
    .DEPTH (RESULT_DEPTH),
    .CNT_W (CNT_W)
  ) result_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (s1_valid),
    .push_data  (result),
    .push_ready (q_push_ready),
    .pop_valid  (res_valid),
    .pop_data   (head),
    .pop_ready  (res_ready),
    .count      (q_count)
  );

  assign res_rob_index = head.rob_idx;
  assign res_value     = head.value;

  // Counts the station's in-flight issue and ignores same-cycle pops, so it errs towards busy.
  assign busy = (32'(s1_valid) + 32'(q_count) + 32'(in_valid)) >= 32'(RESULT_DEPTH + 1);

endmodule

// File: doc/alu_functional_unit.md
Name: alu_functional_unit

Overview:
- Integer ALU functional unit directly downstream of the reservation station.
- Accepts one issued instruction per cycle: ROB index, full 16-bit instruction, two resolved operand values.
- Computes through a fixed 2-stage pipeline, then buffers results in a small queue for the common data bus (CDB) arbiter, using a valid/ready handshake.
- Drives the reservation station's functional-unit-busy input so the station never issues into a full unit.

Parameters:
- RESULT_DEPTH, 2, number of result-queue entries (>=1).
- ROB_IDX_W, 4, ROB index width.
- DATA_W, 16, operand, result and instruction width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all in-flight work (mispredict/exception).
- in_valid  in  1  issue valid (the station's out_valid).
- in_instr_index  in  ROB_IDX_W  ROB index of the issued instruction.
- in_instr_full  in  DATA_W  full instruction; opcode = [15:12].
- in_val1  in  DATA_W  resolved operand 1.
- in_val2  in  DATA_W  resolved operand 2.
- busy  out  1  functional-unit busy, fed to the station.
- res_valid  out  1  result queue head valid (CDB request).
- res_rob_index  out  ROB_IDX_W  head ROB index.
- res_value  out  DATA_W  head result.
- res_ready  in  1  CDB arbiter grant; head pops when res_valid & res_ready.
- overflow_err  out  1  sticky: an issue was dropped for lack of space.

Behaviour:
- Reset (async, rst=1):
  - S1 and queue emptied; queue pointers and count = 0.
  - res_valid=0, res_rob_index=0, res_value=0, overflow_err=0.
  - busy reflects the empty state: busy = in_valid >= RESULT_DEPTH+1, i.e. 0.
- Stage S1: registers index, opcode and operands on the edge where in_valid is accepted.
- Stage S2 (compute):
  - Combinational from S1; result written into the queue tail on the next edge, if the queue has room.
  - Room exists if queue not full, or a pop occurs on the same edge.
- Latency: issue sampled at edge E0 gives res_valid=1 after edge E1 if the queue was empty and not stalled.
- Opcodes; all arithmetic mod 2^16, no flags:
  - 0 ADD, 1 SUB (val1-val2), 2 AND, 3 OR, 4 XOR.
  - 5 SHL by val2[3:0].
  - 6 SHR logical by val2[3:0].
  - 7 SLT signed: result 1 if val1<val2, else 0.
  - 8–15 unsupported (see optional feature): result 0, still broadcast.
- S1 stall: if S1 is valid and the queue has no room, S1 holds.
- Issue acceptance: accept if S1 is empty or S1 advances this edge. Otherwise drop the issue and set overflow_err=1, which stays set until reset.
- busy (combinational): busy = (s1_valid + q_count + in_valid) >= RESULT_DEPTH+1.
  - in_valid is counted because the station's issue is registered, so one issue may already be in flight.
  - Same-cycle pops are ignored (conservative).
- Queue ordering:
  - FIFO; head/tail pointers wrap modulo RESULT_DEPTH.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Pop when empty is ignored.
  - res_rob_index and res_value hold their stable head value while res_valid=1 and res_ready=0.
- flush:
  - On the next edge clears S1 and the queue.
  - Same-cycle in_valid is discarded without setting overflow_err.
  - A same-cycle pop is a don't-care.
  - res_valid=0 after the edge.
- Reset mid-operation: all work is lost immediately, with no partial broadcast.

Optional Feature:
- ALU_MUL_EN defined: opcode 8 = MUL, low 16 bits of val1*val2. The multiply is computed in S2 with the same latency as other ops.
- ALU_MUL_EN undefined: opcode 8 is unsupported (result 0). No multiplier is synthesised.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ADD…OP_MUL);
  - ROB_IDX_W and DATA_W defaults;
  - the issue-bundle typedef {rob_idx, instr, val1, val2};
  - the CDB-entry typedef {rob_idx, value}.
- One natural sub-module: result_fifo, a parameterised-depth valid/ready FIFO of CDB entries exposing count.

Test Plan:
- Back-to-back issues: ADD 3+4 (idx 1), then SUB 2-5 (idx 2), res_ready=1. Expect res_valid two edges after each issue, giving {1,0x0007} then {2,0xFFFD}.
- Backpressure: res_ready=0, issue 4 ops, RESULT_DEPTH=2.
  - busy rises so that the station stops after 3.
  - Forcing a 4th in_valid gives overflow_err=1.
  - After releasing res_ready, 3 results drain in order.
- Shifts and compare:
  - SHL 0x0001 by 0x0013 gives 0x0008 (uses val2[3:0]).
  - SHR 0x8000 by 15 gives 0x0001.
  - SLT 0xFFFF<0x0001 gives 1.
- Flush with 2 queued results plus S1 valid plus in_valid: after the edge res_valid=0, busy=0, overflow_err unchanged.
- Async reset asserted between edges with the queue full: res_valid drops immediately, and all outputs go to 0.
- With ALU_MUL_EN: opcode 8, 0x0100*0x0100 gives 0x0000, and 0x00FF*0x0003 gives 0x02FD. Without ALU_MUL_EN both give 0.
